vga_layer_arbiter: RTL and testbench

Shares the VGA pixel datapath among four rectangular layers plus a background colour. It sits between the VGA timing generator (pixel tick, video_on, x/y) and the 12-bit colour outputs. Each pixel, the highest-priority enabled layer covering (x,y) takes ownership of the colour bus. Layer geometry and colour are written through a valid/ready config port into shadow registers, and the shadow registers are committed to the active set only at a frame boundary, so a frame never tears.

---
 rtl/vga_layer_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_vga_layer_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_layer_arbiter
//  Purpose  : Four-layer rectangle compositor for a VGA pixel stream. Layer
//             geometry/colour is written into shadow registers and copied to
//             the active set only at a frame boundary, so frames never tear.
//             Two-stage pixel pipeline: hit test, then priority select.
//  Revision : 1.0  initial release
// ============================================================================
module vga_layer_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_layer,
  input  logic [2:0]  cfg_field,
  input  logic [11:0] cfg_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic [2:0]  owner,
  output logic        commit
);

  localparam int         NUM_LAYERS = 4;
  localparam logic [2:0] FLD_X0     = 3'd0;
  localparam logic [2:0] FLD_X1     = 3'd1;
  localparam logic [2:0] FLD_Y0     = 3'd2;
  localparam logic [2:0] FLD_Y1     = 3'd3;
  localparam logic [2:0] FLD_COL    = 3'd4;
  localparam logic [2:0] FLD_EN     = 3'd5;
  localparam logic [2:0] FLD_BG     = 3'd6;
  localparam logic [2:0] FLD_RSVD   = 3'd7;
  localparam logic [2:0] OWN_BG     = 3'd4;
  localparam logic [2:0] OWN_BLANK  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Register sets
  // --------------------------------------------------------------------------
  logic [9:0]            sh_x0_q  [NUM_LAYERS];
  logic [9:0]            sh_x1_q  [NUM_LAYERS];
  logic [9:0]            sh_y0_q  [NUM_LAYERS];
  logic [9:0]            sh_y1_q  [NUM_LAYERS];
  logic [11:0]           sh_col_q [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] sh_en_q;
  logic [11:0]           sh_bg_q;
  logic                  dirty_q;

  logic [9:0]            act_x0_q  [NUM_LAYERS];
  logic [9:0]            act_x1_q  [NUM_LAYERS];
  logic [9:0]            act_y0_q  [NUM_LAYERS];
  logic [9:0]            act_y1_q  [NUM_LAYERS];
  logic [11:0]           act_col_q [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] act_en_q;
  logic [11:0]           act_bg_q;

  state_t state_q, state_d;
  logic   commit_go;
  logic   cfg_fire;

  // Writes are refused on frame_tick cycles so they can never race a commit.
  assign cfg_ready = ~reset & ~frame_tick;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // --------------------------------------------------------------------------
  // Commit FSM
  // --------------------------------------------------------------------------

  // State register for the commit sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a frame_tick with pending shadow changes starts a commit.
  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && dirty_q) begin
          commit_go = 1'b1;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign commit = (state_q == ST_COMMIT);

  // --------------------------------------------------------------------------
  // Shadow registers and dirty flag
  // --------------------------------------------------------------------------

  // Accepted config writes land in the shadow set; reserved field is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sh_x0_q[i]  <= '0;
        sh_x1_q[i]  <= '0;
        sh_y0_q[i]  <= '0;
        sh_y1_q[i]  <= '0;
        sh_col_q[i] <= '0;
      end
      sh_en_q <= '0;
      sh_bg_q <= '0;
      dirty_q <= 1'b0;
    end else begin
      if (cfg_fire) begin
        case (cfg_field)
          FLD_X0:  sh_x0_q[cfg_layer]  <= cfg_data[9:0];
          FLD_X1:  sh_x1_q[cfg_layer]  <= cfg_data[9:0];
          FLD_Y0:  sh_y0_q[cfg_layer]  <= cfg_data[9:0];
          FLD_Y1:  sh_y1_q[cfg_layer]  <= cfg_data[9:0];
          FLD_COL: sh_col_q[cfg_layer] <= cfg_data;
          FLD_EN:  sh_en_q[cfg_layer]  <= cfg_data[0];
          FLD_BG:  sh_bg_q             <= cfg_data;
          default: ;
        endcase
      end
      if (cfg_fire && (cfg_field != FLD_RSVD)) begin
        dirty_q <= 1'b1;
      end else if (commit_go) begin
        dirty_q <= 1'b0;
      end
    end
  end

  // Active set: copied wholesale from the shadow set on a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        act_x0_q[i]  <= '0;
        act_x1_q[i]  <= '0;
        act_y0_q[i]  <= '0;
        act_y1_q[i]  <= '0;
        act_col_q[i] <= '0;
      end
      act_en_q <= '0;
      act_bg_q <= '0;
    end else if (commit_go) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        act_x0_q[i]  <= sh_x0_q[i];
        act_x1_q[i]  <= sh_x1_q[i];
        act_y0_q[i]  <= sh_y0_q[i];
        act_y1_q[i]  <= sh_y1_q[i];
        act_col_q[i] <= sh_col_q[i];
      end
      act_en_q <= sh_en_q;
      act_bg_q <= sh_bg_q;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: hit test
  // --------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] hit_d;
  logic [NUM_LAYERS-1:0] hit_q;
  logic [11:0]           col_s1_q [NUM_LAYERS];
  logic [11:0]           bg_s1_q;
  logic                  von_s1_q;

  // Inclusive unsigned bounds; inverted rectangles simply never match.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
    assign hit_d[gi] = act_en_q[gi]
                     & (x >= act_x0_q[gi]) & (x <= act_x1_q[gi])
                     & (y >= act_y0_q[gi]) & (y <= act_y1_q[gi]);
  end

  // Capture hits, visibility and the colours that go with this pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q    <= '0;
      von_s1_q <= 1'b0;
      bg_s1_q  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        col_s1_q[i] <= '0;
      end
    end else if (pix_en) begin
      hit_q    <= hit_d;
      von_s1_q <= video_on;
      bg_s1_q  <= act_bg_q;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        col_s1_q[i] <= act_col_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: priority select
  // --------------------------------------------------------------------------
  logic [11:0] rgb_d, rgb_q;
  logic [2:0]  owner_d, owner_q;

  // Lowest-indexed hit wins, so scan from the top down and let later
  // (lower) indices overwrite.
  always_comb begin
    rgb_d   = '0;
    owner_d = OWN_BLANK;
    if (von_s1_q) begin
      rgb_d   = bg_s1_q;
      owner_d = OWN_BG;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        if (hit_q[i]) begin
          rgb_d   = col_s1_q[i];
          owner_d = 3'(i);
        end
      end
    end
  end

  // Output register; holds its value between pixel ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      owner_q <= OWN_BLANK;
    end else if (pix_en) begin
      rgb_q   <= rgb_d;
      owner_q <= owner_d;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];
  assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_layer_arbiter
//  Purpose  : Directed self-checking bench for vga_layer_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_layer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_tick;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_layer;
  logic [2:0]  cfg_field;
  logic [11:0] cfg_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic [2:0]  owner;
  logic        commit;

  int n_checks = 0;
  int n_errors = 0;

  vga_layer_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_layer  (cfg_layer),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .owner      (owner),
    .commit     (commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel tick: inputs driven at a falling edge, pix_en high for one clock.
  task automatic tick(input logic [9:0] px, input logic [9:0] py, input logic von);
    @(negedge clk);
    x = px; y = py; video_on = von; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // Present a pixel for two ticks so the result reaches the outputs, then check.
  task automatic pixel(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic von, input logic [2:0] exp_own, input logic [11:0] exp_rgb);
    tick(px, py, von);
    tick(px, py, von);
    chk({tag, "_own"}, 16'(owner), 16'(exp_own));
    chk({tag, "_rgb"}, 16'({vga_r, vga_g, vga_b}), 16'(exp_rgb));
  endtask

  task automatic cfg_write(input logic [1:0] l, input logic [2:0] f, input logic [11:0] d);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_layer = l; cfg_field = f; cfg_data = d;
    n = 0;
    while (!cfg_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("cfg_timeout", 16'(cfg_ready), 16'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Pulse frame_tick and count commit pulses seen over the following cycles.
  task automatic do_frame(input string tag, input int exp_commits);
    int cnt;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (commit) cnt++;
      @(negedge clk);
    end
    chk(tag, 16'(cnt), 16'(exp_commits));
  endtask

  task automatic set_rect(input logic [1:0] l, input logic [9:0] x0, input logic [9:0] x1,
                          input logic [9:0] y0, input logic [9:0] y1, input logic [11:0] col);
    cfg_write(l, 3'd0, 12'(x0));
    cfg_write(l, 3'd1, 12'(x1));
    cfg_write(l, 3'd2, 12'(y0));
    cfg_write(l, 3'd3, 12'(y1));
    cfg_write(l, 3'd4, col);
    cfg_write(l, 3'd5, 12'd1);
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; video_on = 1'b0; x = '0; y = '0;
    frame_tick = 1'b0; cfg_valid = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_owner", 16'(owner), 16'd7);
    chk("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
    chk("rst_commit", 16'(commit), 16'd0);
    chk("rst_ready", 16'(cfg_ready), 16'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 16'(cfg_ready), 16'd1);

    // Background only
    pixel("bg0", 10'd100, 10'd100, 1'b1, 3'd4, 12'h000);

    // Layer 1 written but not committed
    set_rect(2'd1, 10'd10, 10'd20, 10'd10, 10'd20, 12'hF00);
    pixel("l1_uncommitted", 10'd15, 10'd15, 1'b1, 3'd4, 12'h000);
    do_frame("commit_l1", 1);
    pixel("l1_committed", 10'd15, 10'd15, 1'b1, 3'd1, 12'hF00);

    // Layer 0 full screen over layer 1, background 00F
    set_rect(2'd0, 10'd0, 10'd639, 10'd0, 10'd479, 12'h0F0);
    cfg_write(2'd0, 3'd6, 12'h00F);
    do_frame("commit_l0", 1);
    pixel("l0_prio", 10'd15, 10'd15, 1'b1, 3'd0, 12'h0F0);
    pixel("outside", 10'd700, 10'd15, 1'b1, 3'd4, 12'h00F);
    pixel("blank", 10'd15, 10'd15, 1'b0, 3'd7, 12'h000);

    // Write held across frame_tick
    @(negedge clk);
    frame_tick = 1'b1; cfg_valid = 1'b1; cfg_layer = 2'd0; cfg_field = 3'd6; cfg_data = 12'h0AA;
    #1;
    chk("ready_on_ft", 16'(cfg_ready), 16'd0);
    @(negedge clk);
    frame_tick = 1'b0;
    #1;
    chk("ready_after_ft", 16'(cfg_ready), 16'd1);
    chk("no_commit_clean", 16'(commit), 16'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    pixel("bg_pending", 10'd700, 10'd15, 1'b1, 3'd4, 12'h00F);
    do_frame("commit_bg", 1);
    pixel("bg_new", 10'd700, 10'd15, 1'b1, 3'd4, 12'h0AA);
    do_frame("no_commit_idle", 0);

    // Reserved field does not dirty the shadow set
    cfg_write(2'd0, 3'd7, 12'hFFF);
    do_frame("no_commit_rsvd", 0);

    // Degenerate and single-column rectangles
    cfg_write(2'd0, 3'd5, 12'd0);
    cfg_write(2'd1, 3'd5, 12'd0);
    set_rect(2'd2, 10'd30, 10'd29, 10'd0, 10'd479, 12'h111);
    set_rect(2'd3, 10'd50, 10'd50, 10'd0, 10'd479, 12'h222);
    do_frame("commit_degen", 1);
    pixel("inv30", 10'd30, 10'd100, 1'b1, 3'd4, 12'h0AA);
    pixel("inv29", 10'd29, 10'd100, 1'b1, 3'd4, 12'h0AA);
    pixel("col50", 10'd50, 10'd100, 1'b1, 3'd3, 12'h222);
    pixel("col49", 10'd49, 10'd100, 1'b1, 3'd4, 12'h0AA);
    pixel("col51", 10'd51, 10'd100, 1'b1, 3'd4, 12'h0AA);

    // Two-tick latency: outputs lag the input pixel by one tick here
    tick(10'd50, 10'd100, 1'b1);
    tick(10'd30, 10'd100, 1'b1);
    chk("lat_a_own", 16'(owner), 16'd3);
    tick(10'd50, 10'd100, 1'b1);
    chk("lat_b_own", 16'(owner), 16'd4);
    repeat (3) @(negedge clk);
    chk("hold_own", 16'(owner), 16'd4);
    chk("hold_rgb", 16'({vga_r, vga_g, vga_b}), 16'h0AA);

    // Reset mid-frame with a layer active and a write in flight
    cfg_write(2'd0, 3'd5, 12'd1);
    do_frame("commit_reen", 1);
    pixel("pre_rst", 10'd15, 10'd15, 1'b1, 3'd0, 12'h0F0);
    @(negedge clk);
    reset = 1'b1; cfg_valid = 1'b1; cfg_layer = 2'd0; cfg_field = 3'd6; cfg_data = 12'hFFF;
    @(negedge clk);
    chk("mid_rst_owner", 16'(owner), 16'd7);
    chk("mid_rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
    chk("mid_rst_ready", 16'(cfg_ready), 16'd0);
    reset = 1'b0; cfg_valid = 1'b0;
    pixel("post_rst", 10'd15, 10'd15, 1'b1, 3'd4, 12'h000);
    do_frame("no_commit_post_rst", 0);
    pixel("post_rst_frame", 10'd15, 10'd15, 1'b1, 3'd4, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
